// File: rtl/program_ram_loader_pkg.sv
// Shared loader definitions: FSM encodings, default frame sync byte and the
// 28-bit instruction field layout used when assembling RAM words.
package program_ram_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_DATA,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } loader_state_e;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  localparam int unsigned INSN_W     = 28;
  localparam int unsigned OPCODE_LSB = 24;
  localparam int unsigned DEST_LSB   = 16;
  localparam int unsigned SRC1_LSB   = 8;
  localparam int unsigned SRC0_LSB   = 0;

  function automatic logic [INSN_W-1:0] pack_insn(input logic [3:0] opcode,
                                                  input logic [7:0] dest,
                                                  input logic [7:0] src1,
                                                  input logic [7:0] src0);
    logic [INSN_W-1:0] w;
    w = '0;
    w[OPCODE_LSB +: 4] = opcode;
    w[DEST_LSB +: 8]   = dest;
    w[SRC1_LSB +: 8]   = src1;
    w[SRC0_LSB +: 8]   = src0;
    return w;
  endfunction

endpackage

// File: rtl/program_ram_loader.sv
// Framed byte-stream loader: assembles big-endian 4-byte words into 28-bit
// instructions, writes them sequentially and releases CPU reset on a good checksum.
module program_ram_loader
  import program_ram_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter logic [7:0]  SYNC  = SYNC_DEFAULT
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [7:0]        iByte,
  input  logic              iByteValid,
  output logic              oByteReady,
  output logic              oWriteEnable,
  output logic [15:0]       oWriteAddress,
  output logic [INSN_W-1:0] oWriteData,
  output logic              oCpuReset,
  output logic              oDone,
  output logic              oError
);

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  loader_state_e     state_q, state_d;
  logic [7:0]        cnt_hi_q, cnt_hi_d;
  logic [15:0]       last_q, last_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [3:0]        opc_q, opc_d;
  logic [7:0]        dest_q, dest_d;
  logic [7:0]        src1_q, src1_d;
  logic [7:0]        csum_q, csum_d;
  logic [15:0]       addr_q, addr_d;
  logic              we_q, we_d;
  logic [INSN_W-1:0] wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              xfer;
  logic [15:0]       count;

  always_comb begin
    state_d    = state_q;
    cnt_hi_d   = cnt_hi_q;
    last_d     = last_q;
    byte_idx_d = byte_idx_q;
    opc_d      = opc_q;
    dest_d     = dest_q;
    src1_d     = src1_q;
    csum_d     = csum_q;
    addr_d     = addr_q;
    we_d       = 1'b0;
    wdata_d    = wdata_q;
    ready_d    = 1'b1;
    cpu_rst_d  = cpu_rst_q;
    done_d     = done_q;
    err_d      = err_q;
    xfer       = iByteValid && ready_q;
    count      = {cnt_hi_q, iByte};

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (xfer && iByte == SYNC) begin
          state_d   = ST_CNT_HI;
          done_d    = 1'b0;
          err_d     = 1'b0;
          cpu_rst_d = 1'b1;
          addr_d    = '0;
          csum_d    = '0;
        end
      end
      ST_CNT_HI: begin
        if (xfer) begin
          cnt_hi_d = iByte;
          csum_d   = csum_q ^ iByte;
          state_d  = ST_CNT_LO;
        end
      end
      ST_CNT_LO: begin
        if (xfer) begin
          csum_d = csum_q ^ iByte;
          if (count == '0 || {1'b0, count} > DEPTH_W) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else begin
            last_d     = count - 16'd1;
            byte_idx_d = '0;
            state_d    = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
          csum_d = csum_q ^ iByte;
          unique case (byte_idx_q)
            2'd0: begin
              if (iByte[7:4] != 4'h0) begin
                state_d = ST_ERROR;
                err_d   = 1'b1;
              end else begin
                opc_d      = iByte[3:0];
                byte_idx_d = 2'd1;
              end
            end
            2'd1: begin
              dest_d     = iByte;
              byte_idx_d = 2'd2;
            end
            2'd2: begin
              src1_d     = iByte;
              byte_idx_d = 2'd3;
            end
            2'd3: begin
              // Strobe and the stall of oByteReady are both registered here so
              // they coincide with the single WRITE cycle.
              wdata_d    = pack_insn(opc_q, dest_q, src1_q, iByte);
              we_d       = 1'b1;
              ready_d    = 1'b0;
              byte_idx_d = 2'd0;
              state_d    = ST_WRITE;
            end
          endcase
        end
      end
      ST_WRITE: begin
        // The last word leaves the address in place so it stays within DEPTH-1.
        if (addr_q == last_q) begin
          state_d = ST_CHECK;
        end else begin
          addr_d  = addr_q + 16'd1;
          state_d = ST_DATA;
        end
      end
      ST_CHECK: begin
        if (xfer) begin
          if (iByte == csum_q) begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      cnt_hi_q   <= '0;
      last_q     <= '0;
      byte_idx_q <= '0;
      opc_q      <= '0;
      dest_q     <= '0;
      src1_q     <= '0;
      csum_q     <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      ready_q    <= 1'b1;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_hi_q   <= cnt_hi_d;
      last_q     <= last_d;
      byte_idx_q <= byte_idx_d;
      opc_q      <= opc_d;
      dest_q     <= dest_d;
      src1_q     <= src1_d;
      csum_q     <= csum_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      ready_q    <= ready_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign oByteReady    = ready_q;
  assign oWriteEnable  = we_q;
  assign oWriteAddress = addr_q;
  assign oWriteData    = wdata_q;
  assign oCpuReset     = cpu_rst_q;
  assign oDone         = done_q;
  assign oError        = err_q;

endmodule

// File: tb/tb_program_ram_loader.sv
// Scoreboard bench for program_ram_loader: directed frames push expected RAM
// writes; a negedge monitor pops and compares every write strobe.
module tb_program_ram_loader;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  iByte = '0;
  logic        iByteValid = 1'b0;
  logic        oByteReady;
  logic        oWriteEnable;
  logic [15:0] oWriteAddress;
  logic [27:0] oWriteData;
  logic        oCpuReset;
  logic        oDone;
  logic        oError;

  typedef struct {
    logic [15:0] addr;
    logic [27:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] frame[$];
  int         total = 0;
  int         bad   = 0;

  program_ram_loader #(.DEPTH(256), .SYNC(8'hA5)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iByte        (iByte),
    .iByteValid   (iByteValid),
    .oByteReady   (oByteReady),
    .oWriteEnable (oWriteEnable),
    .oWriteAddress(oWriteAddress),
    .oWriteData   (oWriteData),
    .oCpuReset    (oCpuReset),
    .oDone        (oDone),
    .oError       (oError)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge Clock) begin
    if (!Reset && oWriteEnable) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                 oWriteAddress, oWriteData);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (oWriteAddress !== e.addr || oWriteData !== e.data) begin
          bad++;
          $display("FAIL write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                   oWriteAddress, oWriteData, e.addr, e.data);
        end
      end
      chk("ready_low_in_write", 32'(oByteReady), 32'd0);
    end
  end

  task automatic expect_wr(input logic [15:0] a, input logic [27:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    @(negedge Clock);
    iByte = b;
    iByteValid = 1'b1;
    waited = 0;
    while (!oByteReady && waited < 20) begin
      @(negedge Clock);
      waited++;
    end
    if (!oByteReady) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: oByteReady stayed 0, required 1");
    end
    @(posedge Clock);
    #1;
    iByteValid = 1'b0;
    for (int i = 0; i < gap; i++) @(negedge Clock);
  endtask

  task automatic send_frame(input int gap);
    foreach (frame[i]) send_byte(frame[i], gap);
  endtask

  task automatic check_status(input string name, input logic d, input logic e, input logic r);
    @(negedge Clock);
    chk({name, "_done"}, 32'(oDone), 32'(d));
    chk({name, "_error"}, 32'(oError), 32'(e));
    chk({name, "_cpu_reset"}, 32'(oCpuReset), 32'(r));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    chk("rst_ready", 32'(oByteReady), 32'd1);
    chk("rst_we", 32'(oWriteEnable), 32'd0);
    chk("rst_addr", 32'(oWriteAddress), 32'd0);
    chk("rst_data", 32'(oWriteData), 32'd0);
    chk("rst_cpu_reset", 32'(oCpuReset), 32'd1);
    chk("rst_done", 32'(oDone), 32'd0);
    chk("rst_error", 32'(oError), 32'd0);

    // Good two-word frame: 02^A0^70^01^C0^50^13 = 0x50
    frame = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'hA0, 8'h70, 8'h01,
              8'h00, 8'hC0, 8'h50, 8'h13, 8'h50};
    expect_wr(16'd0, 28'h0A07001);
    expect_wr(16'd1, 28'h0C05013);
    send_frame(0);
    check_status("good", 1'b1, 1'b0, 1'b0);

    // Same frame, checksum inverted
    frame[11] = 8'hAF;
    expect_wr(16'd0, 28'h0A07001);
    expect_wr(16'd1, 28'h0C05013);
    send_frame(0);
    check_status("badcs", 1'b0, 1'b1, 1'b1);

    frame = '{8'hA5, 8'h00, 8'h00};
    send_frame(0);
    check_status("count0", 1'b0, 1'b1, 1'b1);

    frame = '{8'hA5, 8'h01, 8'h01};
    send_frame(0);
    check_status("count257", 1'b0, 1'b1, 1'b1);

    frame = '{8'hA5, 8'h00, 8'h01, 8'h10, 8'h22, 8'h33, 8'h44};
    send_frame(0);
    check_status("badnibble", 1'b0, 1'b1, 1'b1);

    // Noise then one word: 01^01^23^45^67 = 0x01
    frame = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'h01, 8'h23, 8'h45, 8'h67, 8'h01};
    expect_wr(16'd0, 28'h1234567);
    send_frame(0);
    check_status("noise", 1'b1, 1'b0, 1'b0);

    // Good frame with a gap cycle after every byte
    frame = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'hA0, 8'h70, 8'h01,
              8'h00, 8'hC0, 8'h50, 8'h13, 8'h50};
    expect_wr(16'd0, 28'h0A07001);
    expect_wr(16'd1, 28'h0C05013);
    send_frame(1);
    check_status("gapped", 1'b1, 1'b0, 1'b0);

    // Reset after the first word of a two-word frame
    frame = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'hA0, 8'h70, 8'h01};
    expect_wr(16'd0, 28'h0A07001);
    send_frame(0);
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    chk("mid_rst_ready", 32'(oByteReady), 32'd1);
    chk("mid_rst_addr", 32'(oWriteAddress), 32'd0);
    chk("mid_rst_data", 32'(oWriteData), 32'd0);
    chk("mid_rst_cpu_reset", 32'(oCpuReset), 32'd1);
    chk("mid_rst_done", 32'(oDone), 32'd0);
    chk("mid_rst_error", 32'(oError), 32'd0);

    frame = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h23, 8'h45, 8'h67, 8'h01};
    expect_wr(16'd0, 28'h1234567);
    send_frame(0);
    check_status("reload", 1'b1, 1'b0, 1'b0);

    repeat (4) @(negedge Clock);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
